// File: rtl/alu_operand_stager_if.sv
`default_nettype none
//============================================================================
// Module      : alu_operand_stager_if
// Description : Bundle of the producer-side handshake and the ALU-side
//               request bus of alu_operand_stager.
//               slave  : the stager's view (consumes in_*, drives ALU bus)
//               master : the producer / environment view
// Signals     : in_valid[1:0] operand-present mask (bit0=A, bit1=B)
//               in_ready      stager can accept
//               in_opa/in_opb operands, in_cmd/in_mode/in_cin command info
//               OPA/OPB/CMD/MODE/CIN  registered request to the ALU
//               CE            one-cycle ALU clock-enable per issue
//               INP_VALID     operand mask presented with CE
//               timeout_err   pulse with CE on a timed-out (partial) issue
// Revision    : 1.0 - initial release
//============================================================================
interface alu_operand_stager_if #(
    parameter int DATA_W = 8,
    parameter int CMD_W  = 4
);
    logic [1:0]        in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_opa;
    logic [DATA_W-1:0] in_opb;
    logic [CMD_W-1:0]  in_cmd;
    logic              in_mode;
    logic              in_cin;

    logic [DATA_W-1:0] OPA;
    logic [DATA_W-1:0] OPB;
    logic [CMD_W-1:0]  CMD;
    logic              MODE;
    logic              CIN;
    logic              CE;
    logic [1:0]        INP_VALID;
    logic              timeout_err;

    modport slave (
        input  in_valid, in_opa, in_opb, in_cmd, in_mode, in_cin,
        output in_ready, OPA, OPB, CMD, MODE, CIN, CE, INP_VALID, timeout_err
    );

    modport master (
        output in_valid, in_opa, in_opb, in_cmd, in_mode, in_cin,
        input  in_ready, OPA, OPB, CMD, MODE, CIN, CE, INP_VALID, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/alu_operand_stager.sv
`default_nettype none
//============================================================================
// Module      : alu_operand_stager
// Description : Collects ALU operands that arrive in separate cycles,
//               decodes which operands the latched command needs, and issues
//               one complete single-cycle CE request to the ALU. Incomplete
//               requests are issued partially after TIMEOUT cycles so the ALU
//               flags an error. New input is blocked for ALU_LAT cycles after
//               every issue.
// Ports       : clk  - system clock, rising edge
//               rst  - asynchronous reset, active low
//               bus  - alu_operand_stager_if.slave (producer handshake in,
//                      registered ALU request out)
// Parameters  : DATA_W, CMD_W must match the interface instance.
//               TIMEOUT (>=2) cycles in COLLECT before a partial issue.
//               ALU_LAT (>=1) cycles after issue before accepting again.
// Revision    : 1.0 - initial release
//============================================================================
module alu_operand_stager #(
    parameter int DATA_W  = 8,
    parameter int CMD_W   = 4,
    parameter int TIMEOUT = 16,
    parameter int ALU_LAT = 2
) (
    input  wire logic           clk,
    input  wire logic           rst,
    alu_operand_stager_if.slave bus
);

    localparam int c_TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int c_HW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
    localparam logic [c_TW-1:0] c_TMAX = c_TW'(TIMEOUT - 1);
    localparam logic [c_HW-1:0] c_HMAX = c_HW'(ALU_LAT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    // Operands each command needs: 01 = A only, 10 = B only, 11 = both.
    function automatic logic [1:0] f_req(input logic [CMD_W-1:0] cmd,
                                         input logic             mode);
        logic [1:0] v;
        v = 2'b11;
        if (mode) begin
            case (cmd)
                CMD_W'(4), CMD_W'(5): v = 2'b01;
                CMD_W'(6), CMD_W'(7): v = 2'b10;
                default:              v = 2'b11;
            endcase
        end else begin
            case (cmd)
                CMD_W'(6), CMD_W'(8), CMD_W'(9):   v = 2'b01;
                CMD_W'(7), CMD_W'(10), CMD_W'(11): v = 2'b10;
                default:                           v = 2'b11;
            endcase
        end
        return v;
    endfunction

    // Control state
    state_t            r_state,  w_state_n;
    logic [c_TW-1:0]   r_timer,  w_timer_n;
    logic [c_HW-1:0]   r_hold,   w_hold_n;
    logic [1:0]        r_mask,   w_mask_n;
    logic [1:0]        r_req,    w_req_n;

    // Request being assembled
    logic [DATA_W-1:0] r_opa,    w_opa_n;
    logic [DATA_W-1:0] r_opb,    w_opb_n;
    logic [CMD_W-1:0]  r_cmd,    w_cmd_n;
    logic              r_mode,   w_mode_n;
    logic              r_cin,    w_cin_n;

    // Registered outputs
    logic              r_ready,  w_ready_n;
    logic              r_ce,     w_ce_n;
    logic [1:0]        r_iv,     w_iv_n;
    logic              r_tout,   w_tout_n;
    logic [DATA_W-1:0] r_o_opa,  w_o_opa_n;
    logic [DATA_W-1:0] r_o_opb,  w_o_opb_n;
    logic [CMD_W-1:0]  r_o_cmd,  w_o_cmd_n;
    logic              r_o_mode, w_o_mode_n;
    logic              r_o_cin,  w_o_cin_n;

    logic              w_xfer;
    logic              w_issue;

    // Transfers are qualified by the registered ready that the producer sees.
    assign w_xfer = r_ready && (bus.in_valid != 2'b00);

    always_comb begin
        w_state_n  = r_state;
        w_timer_n  = r_timer;
        w_hold_n   = r_hold;
        w_mask_n   = r_mask;
        w_req_n    = r_req;
        w_opa_n    = r_opa;
        w_opb_n    = r_opb;
        w_cmd_n    = r_cmd;
        w_mode_n   = r_mode;
        w_cin_n    = r_cin;
        w_ready_n  = r_ready;
        w_ce_n     = 1'b0;
        w_iv_n     = 2'b00;
        w_tout_n   = 1'b0;
        w_o_opa_n  = r_o_opa;
        w_o_opb_n  = r_o_opb;
        w_o_cmd_n  = r_o_cmd;
        w_o_mode_n = r_o_mode;
        w_o_cin_n  = r_o_cin;
        w_issue    = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Ready rises here after reset and stays up while idle.
                w_ready_n = 1'b1;
                if (w_xfer) begin
                    w_cmd_n  = bus.in_cmd;
                    w_mode_n = bus.in_mode;
                    w_cin_n  = bus.in_cin;
                    w_req_n  = f_req(bus.in_cmd, bus.in_mode);
                    // Start a fresh request: unreceived operands read as 0.
                    w_opa_n  = bus.in_valid[0] ? bus.in_opa : '0;
                    w_opb_n  = bus.in_valid[1] ? bus.in_opb : '0;
                    w_mask_n = bus.in_valid;
                    if ((w_mask_n & w_req_n) == w_req_n) begin
                        w_issue = 1'b1;
                    end else begin
                        w_state_n = S_COLLECT;
                        w_timer_n = '0;
                    end
                end
            end

            S_COLLECT: begin
                if (w_xfer) begin
                    if (bus.in_valid[0]) w_opa_n = bus.in_opa;
                    if (bus.in_valid[1]) w_opb_n = bus.in_opb;
                    w_mask_n = r_mask | bus.in_valid;
                end
                // Completion is checked first so it wins over a coincident timeout.
                if ((w_mask_n & r_req) == r_req) begin
                    w_issue = 1'b1;
                end else if (r_timer == c_TMAX) begin
                    w_issue  = 1'b1;
                    w_tout_n = 1'b1;
                end else begin
                    w_timer_n = r_timer + 1'b1;
                end
            end

            S_HOLD: begin
                if (r_hold == c_HMAX) begin
                    w_state_n = S_IDLE;
                    w_ready_n = 1'b1;
                    w_mask_n  = 2'b00;
                end else begin
                    w_hold_n = r_hold + 1'b1;
                end
            end

            default: begin
                w_state_n = S_IDLE;
                w_ready_n = 1'b0;
                w_mask_n  = 2'b00;
            end
        endcase

        if (w_issue) begin
            w_o_opa_n  = w_opa_n;
            w_o_opb_n  = w_opb_n;
            w_o_cmd_n  = w_cmd_n;
            w_o_mode_n = w_mode_n;
            w_o_cin_n  = w_cin_n;
            w_ce_n     = 1'b1;
            w_iv_n     = w_mask_n;
            w_ready_n  = 1'b0;
            w_state_n  = S_HOLD;
            w_hold_n   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_hold   <= '0;
            r_mask   <= 2'b00;
            r_req    <= 2'b00;
            r_opa    <= '0;
            r_opb    <= '0;
            r_cmd    <= '0;
            r_mode   <= 1'b0;
            r_cin    <= 1'b0;
            r_ready  <= 1'b0;
            r_ce     <= 1'b0;
            r_iv     <= 2'b00;
            r_tout   <= 1'b0;
            r_o_opa  <= '0;
            r_o_opb  <= '0;
            r_o_cmd  <= '0;
            r_o_mode <= 1'b0;
            r_o_cin  <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_timer  <= w_timer_n;
            r_hold   <= w_hold_n;
            r_mask   <= w_mask_n;
            r_req    <= w_req_n;
            r_opa    <= w_opa_n;
            r_opb    <= w_opb_n;
            r_cmd    <= w_cmd_n;
            r_mode   <= w_mode_n;
            r_cin    <= w_cin_n;
            r_ready  <= w_ready_n;
            r_ce     <= w_ce_n;
            r_iv     <= w_iv_n;
            r_tout   <= w_tout_n;
            r_o_opa  <= w_o_opa_n;
            r_o_opb  <= w_o_opb_n;
            r_o_cmd  <= w_o_cmd_n;
            r_o_mode <= w_o_mode_n;
            r_o_cin  <= w_o_cin_n;
        end
    end

    assign bus.in_ready    = r_ready;
    assign bus.OPA         = r_o_opa;
    assign bus.OPB         = r_o_opb;
    assign bus.CMD         = r_o_cmd;
    assign bus.MODE        = r_o_mode;
    assign bus.CIN         = r_o_cin;
    assign bus.CE          = r_ce;
    assign bus.INP_VALID   = r_iv;
    assign bus.timeout_err = r_tout;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stager.sv
`default_nettype none
//============================================================================
// Module      : tb_alu_operand_stager
// Description : Self-checking bench for alu_operand_stager. Expected issues
//               are queued when stimulus is driven and compared against every
//               CE pulse the DUT produces.
// Revision    : 1.0 - initial release
//============================================================================
module tb_alu_operand_stager;

    typedef struct {
        int         cyc;
        logic [1:0] iv;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] cmd;
        logic       mode;
        logic       cin;
        logic       tout;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   last_k = 0;
    int   k = 0;
    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_operand_stager_if #(.DATA_W(8), .CMD_W(4)) bus();

    alu_operand_stager #(
        .DATA_W (8),
        .CMD_W  (4),
        .TIMEOUT(16),
        .ALU_LAT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int c, input logic [1:0] iv, input logic [7:0] a,
                        input logic [7:0] b, input logic [3:0] cmd, input logic mode,
                        input logic cin, input logic tout);
        exp_t e;
        e.cyc = c; e.iv = iv; e.a = a; e.b = b;
        e.cmd = cmd; e.mode = mode; e.cin = cin; e.tout = tout;
        q.push_back(e);
    endtask

    // Called one time unit after a rising edge; the next edge samples it.
    task automatic drive(input logic [1:0] v, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] cmd, input logic mode, input logic cin);
        bus.in_valid = v;
        bus.in_opa   = a;
        bus.in_opb   = b;
        bus.in_cmd   = cmd;
        bus.in_mode  = mode;
        bus.in_cin   = cin;
        last_k = cyc + 1;
        @(posedge clk);
        #1;
        bus.in_valid = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) chk("ready_timeout", 32'(bus.in_ready), 32'd1);
    endtask

    // Scoreboard: every CE must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.timeout_err && !bus.CE) chk("tout_without_ce", 32'd1, 32'd0);
            if (bus.CE) begin
                if (q.size() == 0) begin
                    chk("unexpected_ce", 32'd1, 32'd0);
                end else begin
                    mon_e = q.pop_front();
                    chk("ce_cycle",  32'(cyc),           32'(mon_e.cyc));
                    chk("inp_valid", 32'(bus.INP_VALID), 32'(mon_e.iv));
                    chk("opa",       32'(bus.OPA),       32'(mon_e.a));
                    chk("opb",       32'(bus.OPB),       32'(mon_e.b));
                    chk("cmd",       32'(bus.CMD),       32'(mon_e.cmd));
                    chk("mode",      32'(bus.MODE),      32'(mon_e.mode));
                    chk("cin",       32'(bus.CIN),       32'(mon_e.cin));
                    chk("tout",      32'(bus.timeout_err), 32'(mon_e.tout));
                    chk("ready_at_ce", 32'(bus.in_ready), 32'd0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 2'b00;
        bus.in_opa   = 8'h00;
        bus.in_opb   = 8'h00;
        bus.in_cmd   = 4'h0;
        bus.in_mode  = 1'b0;
        bus.in_cin   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_ce",    32'(bus.CE),       32'd0);
        chk("rst_iv",    32'(bus.INP_VALID), 32'd0);
        chk("rst_opa",   32'(bus.OPA),      32'd0);
        chk("rst_tout",  32'(bus.timeout_err), 32'd0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(bus.in_ready), 32'd1);

        // 1: ADD, both operands at once, then the HOLD window
        drive(2'b11, 8'h05, 8'h03, 4'd0, 1'b1, 1'b1);
        k = last_k;
        push(k, 2'b11, 8'h05, 8'h03, 4'd0, 1'b1, 1'b1, 1'b0);
        chk("t1_ready_k", 32'(bus.in_ready), 32'd0);
        idle(1);
        chk("t1_ready_k1", 32'(bus.in_ready), 32'd0);
        chk("t1_ce_k1",    32'(bus.CE),       32'd0);
        chk("t1_iv_k1",    32'(bus.INP_VALID), 32'd0);
        chk("t1_opa_held", 32'(bus.OPA),      32'h05);
        idle(1);
        chk("t1_ready_k2", 32'(bus.in_ready), 32'd0);
        idle(1);
        chk("t1_ready_k3", 32'(bus.in_ready), 32'd1);

        // 2: SUB with split operands; command fields in COLLECT are ignored
        drive(2'b01, 8'h10, 8'h00, 4'd1, 1'b1, 1'b0);
        k = last_k;
        idle(3);
        drive(2'b10, 8'hEE, 8'h04, 4'hF, 1'b0, 1'b1);
        push(k + 4, 2'b11, 8'h10, 8'h04, 4'd1, 1'b1, 1'b0, 1'b0);
        wait_ready();

        // 3: single-operand commands issue immediately
        drive(2'b01, 8'hFF, 8'h77, 4'd4, 1'b1, 1'b0);
        push(last_k, 2'b01, 8'hFF, 8'h00, 4'd4, 1'b1, 1'b0, 1'b0);
        wait_ready();
        drive(2'b10, 8'h33, 8'h5A, 4'd7, 1'b0, 1'b0);
        push(last_k, 2'b10, 8'h00, 8'h5A, 4'd7, 1'b0, 1'b0, 1'b0);
        wait_ready();

        // 4: timeout with only A, then B arriving on the timeout edge
        drive(2'b01, 8'hAA, 8'h00, 4'd0, 1'b0, 1'b0);
        k = last_k;
        push(k + 16, 2'b01, 8'hAA, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);
        idle(16);
        wait_ready();
        drive(2'b01, 8'hAA, 8'h00, 4'd0, 1'b0, 1'b0);
        k = last_k;
        idle(15);
        drive(2'b10, 8'h00, 8'hBB, 4'd0, 1'b0, 1'b0);
        push(k + 16, 2'b11, 8'hAA, 8'hBB, 4'd0, 1'b0, 1'b0, 1'b0);
        wait_ready();

        // 5: latest operand wins; input during HOLD is ignored
        drive(2'b01, 8'h11, 8'h00, 4'd2, 1'b1, 1'b0);
        drive(2'b01, 8'h22, 8'h00, 4'd2, 1'b1, 1'b0);
        drive(2'b10, 8'h00, 8'h01, 4'd2, 1'b1, 1'b0);
        push(last_k, 2'b11, 8'h22, 8'h01, 4'd2, 1'b1, 1'b0, 1'b0);
        drive(2'b11, 8'h99, 8'h99, 4'd0, 1'b1, 1'b1);
        wait_ready();
        drive(2'b10, 8'h00, 8'h42, 4'd2, 1'b1, 1'b0);
        drive(2'b01, 8'h24, 8'h00, 4'd0, 1'b0, 1'b1);
        push(last_k, 2'b11, 8'h24, 8'h42, 4'd2, 1'b1, 1'b0, 1'b0);
        wait_ready();

        // 6: reset in the middle of COLLECT aborts everything
        drive(2'b01, 8'h5C, 8'h00, 4'd3, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
        chk("mid_rst_ce",    32'(bus.CE),       32'd0);
        chk("mid_rst_iv",    32'(bus.INP_VALID), 32'd0);
        chk("mid_rst_opa",   32'(bus.OPA),      32'd0);
        chk("mid_rst_opb",   32'(bus.OPB),      32'd0);
        chk("mid_rst_cmd",   32'(bus.CMD),      32'd0);
        chk("mid_rst_mode",  32'(bus.MODE),     32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_mid_rst", 32'(bus.in_ready), 32'd1);
        drive(2'b10, 8'h00, 8'hF0, 4'd0, 1'b0, 1'b1);
        drive(2'b01, 8'h0F, 8'h00, 4'd0, 1'b0, 1'b1);
        push(last_k, 2'b11, 8'h0F, 8'hF0, 4'd0, 1'b0, 1'b1, 1'b0);
        wait_ready();
        idle(4);

        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
